// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous FIFO with a single-cycle clear.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a prefetch queue, decode stall and branch redirect with stale-response drop.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        load_stall_i,
  input  logic        branching_i,
  input  logic [31:0] branching_address_i,
  output logic        instr_valid_o,
  output logic [31:0] fetched_instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_incremented_o
);

  localparam int          CW         = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W    = (CW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q;
  logic [31:0]   last_pc_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          req_accept;
  logic          rsp_drop;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] occupancy;
  fetch_entry_t  q_head, q_push_data;
  logic          unused_ok;

  assign q_push_data = '{instr: imem_rsp_data_i, pc: rsp_pc_q};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (branching_i),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (occupancy)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    imem_req_valid_o = 1'b0;
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    drop_cnt_d       = drop_cnt_q;

    // Credit counts both buffered words and words still in flight, so the queue cannot overflow.
    if (!rst_i && state_q == RUN &&
        ({1'b0, occupancy} + {1'b0, outstanding_q}) < DEPTH_W)
      imem_req_valid_o = 1'b1;

    req_accept    = imem_req_valid_o && imem_req_ready_i;
    rsp_drop      = (drop_cnt_q != '0) || branching_i;
    q_push        = !rst_i && imem_rsp_valid_i && !rsp_drop;
    instr_valid_o = !rst_i && !q_empty;
    q_pop         = instr_valid_o && !load_stall_i && !branching_i;

    outstanding_d = outstanding_q + CW'(req_accept) - CW'(imem_rsp_valid_i);
    if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;

    if (imem_rsp_valid_i && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
    if (state_q == FLUSH && drop_cnt_d == '0) state_d = RUN;

    // Everything still in flight after this edge belongs to the wrong path.
    if (branching_i) begin
      fetch_pc_d = {branching_address_i[31:2], 2'b00};
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_WORD;
      rsp_pc_q      <= RESET_WORD;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      // Responses are in order, so the next kept word is always at the next sequential address.
      if (branching_i)  rsp_pc_q <= {branching_address_i[31:2], 2'b00};
      else if (q_push)  rsp_pc_q <= rsp_pc_q + 32'd4;
      if (!q_empty)     last_pc_q <= q_head.pc;
    end
  end

  assign imem_req_addr_o       = {fetch_pc_q[31:2], 2'b00};
  assign fetched_instruction_o = instr_valid_o ? q_head.instr : NOP_INSTR;
  assign pc_o                  = rst_i ? RESET_PC : (instr_valid_o ? q_head.pc : last_pc_q);
  assign pc_incremented_o      = pc_o + 32'd4;

  assign unused_ok = ^{branching_address_i[1:0], q_full};

endmodule
